// File: rtl/weight_bank.sv
// Per-layer weight matrix store. Serves one layer on the w stream and optionally
// takes the updated matrix back on the result stream; loads weights via the init port.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | accept init (priority) or request; storage load or serve launch
//  S_SERVE     | w held valid and stable until the consumer takes it
//  S_WRITEBACK | wait for result; overwrite latched layer and bump update_count
module weight_bank #(
   parameter int NEURON_NUM        = 5,
   parameter int WEIGHT_CELL_WIDTH = 16,
   parameter int LAYER_NUM         = 4,
   parameter int LAYER_ADDR_WIDTH  = 2,
   parameter int COUNT_WIDTH       = 16
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [LAYER_ADDR_WIDTH-1:0]                         req_layer,
   input  logic                                                req_update,
   input  logic                                                req_valid,
   output logic                                                req_ready,
   output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  w,
   output logic                                                w_valid,
   input  logic                                                w_ready,
   input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  result,
   input  logic                                                result_valid,
   output logic                                                result_ready,
   input  logic [LAYER_ADDR_WIDTH-1:0]                         init_layer,
   input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  init_w,
   input  logic                                                init_valid,
   output logic                                                init_ready,
   output logic                                                busy,
   output logic [COUNT_WIDTH-1:0]                              update_count,
   output logic                                                error
);

   localparam int M = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SERVE     = 2'd1,
      S_WRITEBACK = 2'd2
   } state_t;

   state_t                        r_state;
   logic [M-1:0]                  r_mem [LAYER_NUM];
   logic [M-1:0]                  r_w;
   logic                          r_w_valid;
   logic [LAYER_ADDR_WIDTH-1:0]   r_layer;
   logic                          r_update;
   logic [COUNT_WIDTH-1:0]        r_count;
   logic                          r_error;

   logic [M-1:0]                  w_rd;
   logic                          w_req_ok;
   logic                          w_init_ok;
   logic                          w_idle;

   assign w_idle    = (r_state == S_IDLE);
   assign w_req_ok  = (int'(req_layer) < LAYER_NUM);
   assign w_init_ok = (int'(init_layer) < LAYER_NUM);

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < LAYER_NUM; i++) begin
         if (int'(req_layer) == i) w_rd = r_mem[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         for (int i = 0; i < LAYER_NUM; i++) r_mem[i] <= '0;
         r_w       <= '0;
         r_w_valid <= 1'b0;
         r_layer   <= '0;
         r_update  <= 1'b0;
         r_count   <= '0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // init wins a same-cycle collision; req_ready is low while init_valid is high
               if (init_valid) begin
                  if (w_init_ok) begin
                     for (int i = 0; i < LAYER_NUM; i++) begin
                        if (int'(init_layer) == i) r_mem[i] <= init_w;
                     end
                  end else begin
                     r_error <= 1'b1;
                  end
               end else if (req_valid) begin
                  if (w_req_ok) begin
                     r_layer   <= req_layer;
                     r_update  <= req_update;
                     r_w       <= w_rd;
                     r_w_valid <= 1'b1;
                     r_state   <= S_SERVE;
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end
            S_SERVE: begin
               if (w_ready) begin
                  r_w_valid <= 1'b0;
                  r_state   <= r_update ? S_WRITEBACK : S_IDLE;
               end
            end
            S_WRITEBACK: begin
               if (result_valid) begin
                  for (int i = 0; i < LAYER_NUM; i++) begin
                     if (int'(r_layer) == i) r_mem[i] <= result;
                  end
                  r_count <= r_count + 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign init_ready   = w_idle;
   assign req_ready    = w_idle & ~init_valid;
   assign result_ready = (r_state == S_WRITEBACK);
   assign busy         = ~w_idle;
   assign w            = r_w;
   assign w_valid      = r_w_valid;
   assign update_count = r_count;
   assign error        = r_error;

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank (2x2 matrices, 2 layers, 2-bit update counter).
// Stimulus pushes expected w matrices into a queue; a monitor pops them on each w handshake.
module tb_weight_bank;

   localparam int NN  = 2;
   localparam int WCW = 16;
   localparam int LN  = 2;
   localparam int LAW = 2;
   localparam int CW  = 2;
   localparam int M   = NN * NN * WCW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [LAW-1:0]  req_layer = '0;
   logic            req_update = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [M-1:0]    w;
   logic            w_valid;
   logic            w_ready = 1'b1;
   logic [M-1:0]    result = '0;
   logic            result_valid = 1'b0;
   logic            result_ready;
   logic [LAW-1:0]  init_layer = '0;
   logic [M-1:0]    init_w = '0;
   logic            init_valid = 1'b0;
   logic            init_ready;
   logic            busy;
   logic [CW-1:0]   update_count;
   logic            error;

   int              n_checks = 0;
   int              n_err = 0;
   logic [M-1:0]    exp_q[$];
   logic [M-1:0]    exp_mem [LN];
   int              exp_cnt = 0;
   logic [M-1:0]    mon_hold;
   bit              mon_have = 0;

   weight_bank #(
      .NEURON_NUM(NN), .WEIGHT_CELL_WIDTH(WCW), .LAYER_NUM(LN),
      .LAYER_ADDR_WIDTH(LAW), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_layer(req_layer), .req_update(req_update), .req_valid(req_valid), .req_ready(req_ready),
      .w(w), .w_valid(w_valid), .w_ready(w_ready),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .init_layer(init_layer), .init_w(init_w), .init_valid(init_valid), .init_ready(init_ready),
      .busy(busy), .update_count(update_count), .error(error)
   );

   always #5 clk = ~clk;

   function automatic logic [M-1:0] mk(int a, int b, int c, int d);
      return {16'(a), 16'(b), 16'(c), 16'(d)};
   endfunction

   task automatic chk(string name, logic [M-1:0] act, logic [M-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_to(string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timeout, got no handshake, expected one within 20 cycles", name);
   endtask

   // Scoreboard monitor: w must stay stable while stalled; each handshake pops one expectation.
   always @(negedge clk) begin
      if (rst && w_valid) begin
         if (mon_have) chk("w_stable", w, mon_hold);
         mon_hold = w;
         mon_have = 1;
         if (w_ready) begin
            mon_have = 0;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL w_unexpected: got %h, expected no serve", w);
            end else begin
               chk("w_data", w, exp_q.pop_front());
            end
         end
      end else begin
         mon_have = 0;
      end
   end

   task automatic wait_req_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
   endtask

   task automatic wait_result_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (result_ready) begin ok = 1; break; end
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) fail_to("wait_idle");
      @(posedge clk); #1;
   endtask

   task automatic do_init(int layer, logic [M-1:0] mat);
      init_layer = LAW'(layer);
      init_w     = mat;
      init_valid = 1'b1;
      @(posedge clk); #1;
      init_valid = 1'b0;
      if (layer < LN) exp_mem[layer] = mat;
   endtask

   task automatic do_req(int layer, bit upd, bit push);
      bit ok;
      req_layer  = LAW'(layer);
      req_update = upd;
      req_valid  = 1'b1;
      wait_req_ready(ok);
      if (!ok) fail_to("req_accept");
      else if (push) exp_q.push_back(exp_mem[layer]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (push) chk("w_valid_latency", M'(w_valid), M'(1));
   endtask

   task automatic do_update(int layer, logic [M-1:0] newmat);
      bit ok;
      result       = newmat;
      result_valid = 1'b1;
      w_ready      = 1'b1;
      do_req(layer, 1'b1, 1'b1);
      wait_result_ready(ok);
      if (!ok) fail_to("result_accept");
      @(posedge clk); #1;
      result_valid = 1'b0;
      exp_mem[layer] = newmat;
      exp_cnt = (exp_cnt + 1) % 4;
      chk("update_count", M'(update_count), M'(exp_cnt));
      chk("busy_after_wb", M'(busy), M'(0));
   endtask

   task automatic apply_reset();
      #1 rst = 1'b0;
      #1;
      exp_q.delete();
      for (int i = 0; i < LN; i++) exp_mem[i] = '0;
      exp_cnt = 0;
      chk("rst_w_valid", M'(w_valid), M'(0));
      chk("rst_busy", M'(busy), M'(0));
      chk("rst_count", M'(update_count), M'(0));
      chk("rst_error", M'(error), M'(0));
      chk("rst_w", w, '0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < LN; i++) exp_mem[i] = '0;
      @(posedge clk); #1;
      apply_reset();
      chk("idle_req_ready", M'(req_ready), M'(1));
      chk("idle_init_ready", M'(init_ready), M'(1));

      // 1: reset mid-serve abandons it and clears storage
      do_init(0, mk(9, 9, 9, 9));
      w_ready = 1'b0;
      do_req(0, 1'b0, 1'b0);
      chk("serve_busy", M'(busy), M'(1));
      apply_reset();
      w_ready = 1'b1;
      do_req(0, 1'b0, 1'b1);
      wait_idle();

      // 2: read-only serve
      do_init(1, mk(4, 3, 2, 1));
      do_req(1, 1'b0, 1'b1);
      wait_idle();
      chk("count_readonly", M'(update_count), M'(0));

      // 3: stalled serve then write-back
      do_init(0, mk(1, 1, 1, 1));
      w_ready = 1'b0;
      do_req(0, 1'b1, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_w_valid", M'(w_valid), M'(1));
         chk("stall_w", w, mk(1, 1, 1, 1));
      end
      w_ready = 1'b1;
      @(posedge clk); #1;
      chk("wb_result_ready", M'(result_ready), M'(1));
      chk("wb_w_valid", M'(w_valid), M'(0));
      result = mk(5, -2, 0, 7);
      result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
      exp_mem[0] = mk(5, -2, 0, 7);
      exp_cnt = 1;
      chk("count_after_wb", M'(update_count), M'(1));
      do_req(0, 1'b0, 1'b1);
      wait_idle();

      // 4: init and request collide; init first, request next cycle
      init_layer = 1;  init_w = mk(10, 20, 30, 40);  init_valid = 1'b1;
      req_layer  = 1;  req_update = 1'b0;            req_valid  = 1'b1;
      @(negedge clk);
      chk("collide_req_ready", M'(req_ready), M'(0));
      chk("collide_init_ready", M'(init_ready), M'(1));
      @(posedge clk); #1;
      init_valid = 1'b0;
      exp_mem[1] = mk(10, 20, 30, 40);
      @(negedge clk);
      chk("post_collide_req_ready", M'(req_ready), M'(1));
      exp_q.push_back(exp_mem[1]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("collide_w_valid", M'(w_valid), M'(1));
      wait_idle();

      // 5: out-of-range layers
      chk("error_clear", M'(error), M'(0));
      do_req(3, 1'b0, 1'b0);
      chk("oor_error", M'(error), M'(1));
      chk("oor_w_valid", M'(w_valid), M'(0));
      chk("oor_busy", M'(busy), M'(0));
      do_init(2, mk(-1, -1, -1, -1));
      chk("oor_error_sticky", M'(error), M'(1));
      do_req(1, 1'b0, 1'b1);
      wait_idle();
      do_req(0, 1'b0, 1'b1);
      wait_idle();

      // 6a: result_valid during serve is not consumed
      w_ready = 1'b0;
      result = mk(7, 7, 7, 7);
      result_valid = 1'b1;
      do_req(0, 1'b1, 1'b1);
      repeat (2) begin
         @(negedge clk);
         chk("serve_result_ready", M'(result_ready), M'(0));
         @(posedge clk); #1;
      end
      result_valid = 1'b0;
      chk("serve_count_hold", M'(update_count), M'(exp_cnt));
      w_ready = 1'b1;
      @(posedge clk); #1;
      result = mk(1, 2, 3, 4);
      result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
      exp_mem[0] = mk(1, 2, 3, 4);
      exp_cnt = (exp_cnt + 1) % 4;
      chk("count_6a", M'(update_count), M'(exp_cnt));
      do_req(0, 1'b0, 1'b1);
      wait_idle();

      // 6b: counter wraps after five write-backs from reset
      apply_reset();
      for (int i = 0; i < 5; i++) do_update(i % 2, mk(i, -i, 100 + i, 3 * i));
      chk("count_wrap", M'(update_count), M'(1));
      do_req(0, 1'b0, 1'b1);
      wait_idle();
      do_req(1, 1'b0, 1'b1);
      wait_idle();

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", M'(exp_q.size()), M'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1);
   end

endmodule
